// File: rtl/pconv_feeder_c6_pkg.sv
// Shared definitions for the pointwise-conv input feeder: state encoding,
// address-width helper and the channel count shared with the conv array.
package pconv_feeder_c6_pkg;

  localparam int CHANNEL_DEFAULT = 6;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_STREAM = 2'd1,
    ST_WAIT   = 2'd2,
    ST_DONE   = 2'd3
  } state_t;

  // Address width for a buffer of `depth` words; never narrower than one bit.
  function automatic int addr_w_f(input int depth);
    return (depth <= 2) ? 1 : $clog2(depth);
  endfunction

endpackage

// File: rtl/pconv_feeder_c6_fmap_bank.sv
// One channel plane of the feature map: synchronous write port and a
// registered read port whose output holds between reads.
module fmap_bank #(
  parameter int N     = 16,
  parameter int DEPTH = 36,
  parameter int AW    = 6
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [N-1:0]  wdata,
  input  logic          re,
  input  logic [AW-1:0] raddr,
  output logic [N-1:0]  rdata
);

  logic [N-1:0] mem [DEPTH];

  // NOTE: the storage array has no reset so it maps onto plain RAM; only the
  // read register below is cleared.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  always_ff @(posedge clk) begin
    if (rst)     rdata <= '0;
    else if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/pconv_feeder_c6.sv
// Feature-map buffer plus replay sequencer feeding a 6-input pointwise conv:
// load channel-planar in IDLE, stream raster-order beats, wait for conv end.
module pconv_feeder_c6
  import pconv_feeder_c6_pkg::*;
#(
  parameter int N          = 16,
  parameter int CHANNEL    = CHANNEL_DEFAULT,
  parameter int INPUT_SIZE = 6,
  parameter int ADDR_W     = addr_w_f(INPUT_SIZE * INPUT_SIZE)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 wr_en,
  input  logic [2:0]           wr_ch,
  input  logic [ADDR_W-1:0]    wr_addr,
  input  logic [N-1:0]         wr_data,
  input  logic                 start,
  input  logic                 stall,
  output logic                 conv_ce,
  output logic                 conv_vld,
  output logic [CHANNEL*N-1:0] conv_din,
  input  logic                 conv_end,
  output logic                 busy,
  output logic                 done
);

  localparam int                PIX    = INPUT_SIZE * INPUT_SIZE;
  localparam logic [ADDR_W-1:0] LAST_P = ADDR_W'(PIX - 1);

  state_t            state, state_next;
  logic [ADDR_W-1:0] p;
  logic              seen_low;
  logic              rd_issue;
  logic              wr_ok;
  logic              restart;

  // Out-of-range addresses and any write outside IDLE are dropped here;
  // out-of-range channels simply match no bank.
  assign wr_ok   = wr_en && (state == ST_IDLE) && (int'(wr_addr) < PIX);
  assign restart = (state == ST_IDLE) && start;

  for (genvar g = 0; g < CHANNEL; g++) begin : g_bank
    fmap_bank #(
      .N    (N),
      .DEPTH(PIX),
      .AW   (ADDR_W)
    ) u_bank (
      .clk  (clk),
      .rst  (rst),
      .we   (wr_ok && (wr_ch == 3'(g))),
      .waddr(wr_addr),
      .wdata(wr_data),
      .re   (rd_issue),
      .raddr(p),
      .rdata(conv_din[g*N +: N])
    );
  end

  // NOTE: every signal driven here gets a default first so no latch is inferred.
  always_comb begin
    state_next = state;
    rd_issue   = 1'b0;
    case (state)
      ST_IDLE:   if (start) state_next = ST_STREAM;
      ST_STREAM: begin
        if (!stall) begin
          rd_issue = 1'b1;
          if (p == LAST_P) state_next = ST_WAIT;
        end
      end
      ST_WAIT:   if (seen_low && conv_end) state_next = ST_DONE;
      ST_DONE:   state_next = ST_IDLE;
      default:   state_next = ST_IDLE;
    endcase
  end

  // NOTE: registers use non-blocking assignments so all of them update from
  // the same pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_IDLE;
      p        <= '0;
      seen_low <= 1'b0;
      conv_vld <= 1'b0;
    end else begin
      state    <= state_next;
      conv_vld <= rd_issue;

      if (restart || state == ST_DONE) p <= '0;
      else if (rd_issue)               p <= (p == LAST_P) ? '0 : p + 1'b1;

      // The conv must have accepted work (end low) before its end flag counts.
      if (restart || state == ST_DONE)
        seen_low <= 1'b0;
      else if ((state == ST_STREAM || state == ST_WAIT) && !conv_end)
        seen_low <= 1'b1;
    end
  end

  assign conv_ce = (state == ST_STREAM) || (state == ST_WAIT);
  assign busy    = (state != ST_IDLE);
  assign done    = (state == ST_DONE);

endmodule

// File: tb/tb_pconv_feeder_c6.sv
// Self-checking bench: random map contents and stall patterns against an
// array model of the map and a conv end-flag model driven by observed beats.
module tb_pconv_feeder_c6;

  localparam int N   = 16;
  localparam int CH  = 6;
  localparam int PIX = 36;

  logic            clk = 1'b0;
  logic            rst;
  logic            wr_en;
  logic [2:0]      wr_ch;
  logic [5:0]      wr_addr;
  logic [N-1:0]    wr_data;
  logic            start;
  logic            stall;
  logic            conv_ce;
  logic            conv_vld;
  logic [CH*N-1:0] conv_din;
  logic            conv_end;
  logic            busy;
  logic            done;

  int total = 0;
  int bad   = 0;

  logic [N-1:0] model [CH][PIX];

  always #5 clk = ~clk;

  pconv_feeder_c6 dut (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (wr_en),
    .wr_ch   (wr_ch),
    .wr_addr (wr_addr),
    .wr_data (wr_data),
    .start   (start),
    .stall   (stall),
    .conv_ce (conv_ce),
    .conv_vld(conv_vld),
    .conv_din(conv_din),
    .conv_end(conv_end),
    .busy    (busy),
    .done    (done)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic write_px(input int c, input int a, input logic [N-1:0] d);
    wr_en = 1'b1; wr_ch = 3'(c); wr_addr = 6'(a); wr_data = d;
    tick();
    wr_en = 1'b0;
  endtask

  task automatic load_map(input bit random_data);
    logic [N-1:0] d;
    for (int c = 0; c < CH; c++) begin
      for (int a = 0; a < PIX; a++) begin
        d = random_data ? N'($urandom) : N'((c << 8) | a);
        model[c][a] = d;
        write_px(c, a, d);
      end
    end
  endtask

  // One full replay. stall_kind: 0 none, 1 every third cycle, 2 random.
  // rst_beat > 0 aborts with a reset right after that many beats.
  task automatic run_stream(input string name, input int stall_kind,
                            input bit busy_write, input bit beef,
                            input int rst_beat);
    int issued, first_b, last_b, rise, done_cyc, done_n;
    bit st, ce_v;
    logic [CH*N-1:0] exp_din;

    if (beef) begin
      wr_en = 1'b1; wr_ch = 3'd0; wr_addr = 6'd0; wr_data = 16'hBEEF;
      model[0][0] = 16'hBEEF;
    end
    conv_end = 1'b1;
    start = 1'b1;
    tick();
    start = 1'b0;
    wr_en = 1'b0;
    total++;
    if (busy !== 1'b1 || conv_ce !== 1'b1 || conv_vld !== 1'b0) begin
      bad++;
      $display("FAIL %s start: busy/ce/vld got %b%b%b exp 110", name, busy, conv_ce, conv_vld);
    end

    issued = 0; first_b = 0; last_b = 0; rise = 0; done_cyc = 0; done_n = 0;
    for (int cyc = 1; cyc <= 300; cyc++) begin
      case (stall_kind)
        1:       st = (cyc % 3 == 2);
        2:       st = ($urandom_range(0, 3) == 0);
        default: st = 1'b0;
      endcase
      stall = st;
      ce_v = !(first_b > 0 && cyc >= first_b + 2 && (last_b == 0 || cyc < last_b + 5));
      conv_end = ce_v;
      if (ce_v && last_b > 0 && rise == 0) rise = cyc;
      if (busy_write && cyc == 5) begin
        wr_en = 1'b1; wr_ch = 3'd1; wr_addr = 6'd5; wr_data = N'($urandom);
      end
      if (done_cyc > 0 && cyc == done_cyc + 1) begin
        wr_en = 1'b1; wr_ch = 3'd2; wr_addr = 6'd7; wr_data = N'($urandom);
      end
      tick();
      wr_en = 1'b0;
      stall = 1'b0;

      total++;
      if (conv_vld !== (!st && issued < PIX)) begin
        bad++;
        $display("FAIL %s vld cyc %0d: got %b exp %b", name, cyc, conv_vld, !st && issued < PIX);
      end
      if (!st && issued < PIX) begin
        for (int c = 0; c < CH; c++) exp_din[c*N +: N] = model[c][issued];
        total++;
        if (conv_din !== exp_din) begin
          bad++;
          $display("FAIL %s beat %0d din: got %h exp %h", name, issued, conv_din, exp_din);
        end
        issued++;
        if (first_b == 0) first_b = cyc;
        if (issued == PIX) last_b = cyc;
        if (rst_beat > 0 && issued == rst_beat) begin
          rst = 1'b1;
          tick();
          rst = 1'b0;
          conv_end = 1'b1;
          total++;
          if (conv_ce !== 1'b0 || conv_vld !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
            bad++;
            $display("FAIL %s mid_reset: ce/vld/busy/done got %b%b%b%b exp 0000",
                     name, conv_ce, conv_vld, busy, done);
          end
          return;
        end
      end

      if (done === 1'b1) begin
        done_n++;
        if (done_cyc == 0) done_cyc = cyc;
      end
      if (done_cyc > 0 && cyc == done_cyc + 1) begin
        total++;
        if (busy !== 1'b0 || done !== 1'b0 || conv_ce !== 1'b0) begin
          bad++;
          $display("FAIL %s after_done: busy/done/ce got %b%b%b exp 000", name, busy, done, conv_ce);
        end
        break;
      end else if (done_cyc == 0) begin
        total++;
        if (busy !== 1'b1 || conv_ce !== 1'b1) begin
          bad++;
          $display("FAIL %s active cyc %0d: busy/ce got %b%b exp 11", name, cyc, busy, conv_ce);
        end
      end
    end

    total++;
    if (issued != PIX) begin
      bad++;
      $display("FAIL %s beat_count: got %0d exp %0d", name, issued, PIX);
    end
    total++;
    if (rise == 0 || done_cyc != rise || done_n != 1) begin
      bad++;
      $display("FAIL %s done_timing: done cyc %0d count %0d exp cyc %0d count 1",
               name, done_cyc, done_n, rise);
    end
    if (stall_kind == 0) begin
      total++;
      if (first_b != 1 || last_b != PIX) begin
        bad++;
        $display("FAIL %s beat_window: got %0d..%0d exp 1..%0d", name, first_b, last_b, PIX);
      end
    end
    conv_end = 1'b1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    total++;
    if (conv_ce !== 1'b0 || conv_vld !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
      bad++;
      $display("FAIL reset ctrl: ce/vld/busy/done got %b%b%b%b exp 0000", conv_ce, conv_vld, busy, done);
    end
    total++;
    if (conv_din !== '0) begin
      bad++;
      $display("FAIL reset din: got %h exp 0", conv_din);
    end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_basic();
    load_map(1'b0);
    run_stream("basic", 0, 1'b0, 1'b0, 0);
  endtask

  task automatic test_stall();
    load_map(1'b1);
    run_stream("stall3", 1, 1'b0, 1'b0, 0);
    run_stream("stall_rand", 2, 1'b0, 1'b0, 0);
  endtask

  task automatic test_ignored_writes();
    write_px(6, 3, 16'h1234);
    write_px(7, 0, 16'h5678);
    write_px(0, 36, 16'h9ABC);
    write_px(3, 63, 16'hDEF0);
    run_stream("busy_write", 2, 1'b1, 1'b0, 0);
    run_stream("replay", 0, 1'b0, 1'b0, 0);
  endtask

  task automatic test_mid_reset();
    run_stream("mid_reset", 0, 1'b0, 1'b0, 10);
    tick();
    run_stream("after_reset", 0, 1'b0, 1'b0, 0);
  endtask

  task automatic test_write_with_start();
    run_stream("beef", 0, 1'b0, 1'b1, 0);
  endtask

  initial begin
    rst = 1'b1; wr_en = 1'b0; wr_ch = '0; wr_addr = '0; wr_data = '0;
    start = 1'b0; stall = 1'b0; conv_end = 1'b1;
    test_reset();
    test_basic();
    test_stall();
    test_ignored_writes();
    test_mid_reset();
    test_write_with_start();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
